// File: rtl/pwm_advanced_defs.sv
// pwm_advanced_defs: shared FSM encoding and edge arithmetic helper for the half-bridge PWM timebase
package pwm_advanced_defs;
  typedef enum logic [1:0] {IDLE, CLAMP, COMPUTE, PENDING} state_t;
  // true when a+b would clip if saturated to lim
  function automatic logic add_saturates(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lim);
    return ({1'b0, a} + {1'b0, b}) > {1'b0, lim};
  endfunction
endpackage

// File: rtl/pwm_advanced_halfbridge_timebase.sv
// pwm_advanced_halfbridge_timebase: PWM counter plus update sequencer that hands gate edge ticks to the gate stage at period boundaries
module pwm_advanced_halfbridge_timebase
  import pwm_advanced_defs::*;
#(
  parameter int bitwidth = 8,
  parameter int deadtime_bitwidth = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         update_valid,
  output logic                         update_ready,
  input  logic [bitwidth-1:0]          counter_maximum,
  input  logic [bitwidth-1:0]          duty_value,
  input  logic [deadtime_bitwidth-1:0] deadtime,
  output logic [bitwidth-1:0]          counter_value,
  output logic                         load_enable,
  output logic                         period_start,
  output logic [bitwidth-1:0]          tick_number_rising_edge_highside,
  output logic [bitwidth-1:0]          tick_number_falling_edge_highside,
  output logic [bitwidth-1:0]          tick_number_rising_edge_lowside,
  output logic [bitwidth-1:0]          tick_number_falling_edge_lowside
);
  localparam int W = bitwidth + 1;
  state_t                       state;
  logic [bitwidth-1:0]          active_max, max_s, duty_s, duty_eff;
  logic [deadtime_bitwidth-1:0] dt_s, dt_eff;
  logic [bitwidth-1:0]          sh_hs_rise, sh_hs_fall, sh_ls_rise;
  logic [bitwidth-1:0]          nx_hs_rise, nx_hs_fall, nx_ls_rise;
  logic [W-1:0]                 max_w, dt_c, lo_w, hi_w, duty_c;
  logic [bitwidth-1:0]          counter_next;
  logic                         ls_sat, fire;

  assign update_ready = state == IDLE;
  assign period_start = counter_value == '0;
  assign tick_number_falling_edge_lowside = '0;

  // clamp dead time and duty in one extra bit so max+1 never overflows
  always_comb begin
    max_w = W'(max_s);
    dt_c = W'(dt_s) < (max_w >> 1) ? W'(dt_s) : (max_w >> 1);
    lo_w = W'(duty_s) > dt_c ? W'(duty_s) : dt_c;
    hi_w = max_w + W'(1) - dt_c;
    duty_c = lo_w < hi_w ? lo_w : hi_w;
  end

  // edge tick numbers from the clamped values; a clipped lowside rise disables the lowside
  always_comb begin
    ls_sat = add_saturates(32'(duty_eff), 32'(dt_eff), 32'(max_s));
    nx_hs_rise = bitwidth'(dt_eff);
    nx_hs_fall = duty_eff;
    nx_ls_rise = ls_sat ? '0 : duty_eff + bitwidth'(dt_eff);
  end

  // load_enable is raised on the edge entering the last cycle of a period, which then always wraps
  always_comb begin
    counter_next = (counter_value == active_max || load_enable) ? '0 : counter_value + bitwidth'(1);
    fire = (state == COMPUTE || (state == PENDING && !load_enable)) && counter_next == active_max;
  end

  // free-running period counter
  always_ff @(posedge clock or posedge reset)
    if (reset) counter_value <= '0;
    else counter_value <= counter_next;

  // update FSM, clamp/compute pipeline and glitch-free adoption of new ticks and period length
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      load_enable <= 1'b0;
      active_max <= '0;
      max_s <= '0;
      duty_s <= '0;
      dt_s <= '0;
      dt_eff <= '0;
      duty_eff <= '0;
      sh_hs_rise <= '0;
      sh_hs_fall <= '0;
      sh_ls_rise <= '0;
      tick_number_rising_edge_highside <= '0;
      tick_number_falling_edge_highside <= '0;
      tick_number_rising_edge_lowside <= '0;
    end else begin
      state <= state == IDLE ? (update_valid ? CLAMP : IDLE) :
               state == CLAMP ? COMPUTE :
               state == COMPUTE ? PENDING :
               load_enable ? IDLE : PENDING;
      load_enable <= fire;
      if (update_valid && update_ready) begin
        max_s <= counter_maximum;
        duty_s <= duty_value;
        dt_s <= deadtime;
      end
      if (state == CLAMP) begin
        dt_eff <= deadtime_bitwidth'(dt_c);
        duty_eff <= bitwidth'(duty_c);
      end
      if (state == COMPUTE) begin
        sh_hs_rise <= nx_hs_rise;
        sh_hs_fall <= nx_hs_fall;
        sh_ls_rise <= nx_ls_rise;
      end
      if (fire) begin
        active_max <= max_s;
        tick_number_rising_edge_highside <= state == COMPUTE ? nx_hs_rise : sh_hs_rise;
        tick_number_falling_edge_highside <= state == COMPUTE ? nx_hs_fall : sh_hs_fall;
        tick_number_rising_edge_lowside <= state == COMPUTE ? nx_ls_rise : sh_ls_rise;
      end
    end
endmodule

// File: tb/tb_pwm_advanced_halfbridge_timebase.sv
// tb_pwm_advanced_halfbridge_timebase: randomized and directed check of the timebase against a period-level model
module tb_pwm_advanced_halfbridge_timebase;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       update_valid = 1'b0;
  logic       update_ready;
  logic [7:0] counter_maximum = '0;
  logic [7:0] duty_value = '0;
  logic [3:0] deadtime = '0;
  logic [7:0] counter_value;
  logic       load_enable;
  logic       period_start;
  logic [7:0] hs_rise, hs_fall, ls_rise, ls_fall;
  int errors = 0;
  int checks = 0;

  pwm_advanced_halfbridge_timebase #(.bitwidth(8), .deadtime_bitwidth(4)) dut (
    .clock(clock), .reset(reset),
    .update_valid(update_valid), .update_ready(update_ready),
    .counter_maximum(counter_maximum), .duty_value(duty_value), .deadtime(deadtime),
    .counter_value(counter_value), .load_enable(load_enable), .period_start(period_start),
    .tick_number_rising_edge_highside(hs_rise), .tick_number_falling_edge_highside(hs_fall),
    .tick_number_rising_edge_lowside(ls_rise), .tick_number_falling_edge_lowside(ls_fall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // period-level model: counter runs 0..period_max; a settings transfer becomes visible
  // (ticks, load pulse) in the last cycle of the first period ending 3+ cycles after the
  // handshake cycle, and the new length applies from the following period
  int  m_cnt, m_pmax, m_age, m_hr, m_hf, m_lr, m_lf;
  int  n_max, n_hr, n_hf, n_lr;
  bit  m_busy, exp_le, ready_now;
  initial forever begin
    @(negedge clock);
    if (reset) begin
      m_cnt = 0; m_pmax = 0; m_age = 0; m_busy = 0;
      m_hr = 0; m_hf = 0; m_lr = 0; m_lf = 0;
    end else begin
      if (m_busy) m_age++;
      exp_le = m_busy && m_age >= 3 && m_cnt == m_pmax;
      if (exp_le) begin m_hr = n_hr; m_hf = n_hf; m_lr = n_lr; m_lf = 0; end
      chk("counter", 32'(counter_value), m_cnt);
      chk("period_start", 32'(period_start), 32'(m_cnt == 0));
      chk("ready", 32'(update_ready), 32'(!m_busy));
      chk("load_enable", 32'(load_enable), 32'(exp_le));
      chk("hs_rise", 32'(hs_rise), m_hr);
      chk("hs_fall", 32'(hs_fall), m_hf);
      chk("ls_rise", 32'(ls_rise), m_lr);
      chk("ls_fall", 32'(ls_fall), m_lf);
      ready_now = !m_busy;
      m_cnt = (m_cnt == m_pmax) ? 0 : m_cnt + 1;
      if (exp_le) begin m_pmax = n_max; m_busy = 0; end
      if (ready_now && update_valid) begin
        int mx, dte, lo, hi, de;
        mx = int'(counter_maximum);
        dte = int'(deadtime) < mx / 2 ? int'(deadtime) : mx / 2;
        lo = int'(duty_value) > dte ? int'(duty_value) : dte;
        hi = mx + 1 - dte;
        de = lo < hi ? lo : hi;
        n_max = mx; n_hr = dte; n_hf = de;
        n_lr = (de + dte > mx) ? 0 : de + dte;
        m_busy = 1; m_age = 0;
      end
    end
  end

  task automatic send(input int mx, input int du, input int dt);
    @(posedge clock); #1;
    counter_maximum = 8'(mx); duty_value = 8'(du); deadtime = 4'(dt); update_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (update_ready) break;
    end
    chk("send_ready", 32'(update_ready), 1);
    @(posedge clock); #1;
    update_valid = 1'b0;
  endtask

  task automatic wait_load;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (load_enable) break;
    end
    chk("load_seen", 32'(load_enable), 1);
  endtask

  task automatic pin(input int cnt, input int a, input int b, input int c, input int d);
    chk("pin_counter", 32'(counter_value), cnt);
    chk("pin_hs_rise", 32'(hs_rise), a);
    chk("pin_hs_fall", 32'(hs_fall), b);
    chk("pin_ls_rise", 32'(ls_rise), c);
    chk("pin_ls_fall", 32'(ls_fall), d);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 chk("rst_counter", 32'(counter_value), 0);
    chk("rst_ready", 32'(update_ready), 1);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    // first load lands right after compute because the reset period length is one tick
    send(99, 50, 5);
    wait_load;
    pin(0, 5, 50, 55, 0);
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (counter_value == 8'd99) break;
    end
    @(negedge clock);
    chk("wrap_to_zero", 32'(counter_value), 0);
    chk("wrap_period_start", 32'(period_start), 1);
    send(99, 30, 5);
    wait_load;
    pin(99, 5, 30, 35, 0);
    send(99, 2, 5);
    wait_load;
    pin(99, 5, 5, 10, 0);
    send(99, 99, 5);
    wait_load;
    pin(99, 5, 95, 0, 0);
    send(9, 5, 15);
    wait_load;
    pin(99, 4, 5, 9, 0);
    send(49, 20, 3);
    wait_load;
    pin(9, 3, 20, 23, 0);
    // asynchronous reset while the update sits in COMPUTE
    send(49, 10, 2);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("arst_counter", 32'(counter_value), 0);
    chk("arst_load_enable", 32'(load_enable), 0);
    chk("arst_ready", 32'(update_ready), 1);
    chk("arst_hs_fall", 32'(hs_fall), 0);
    chk("arst_ls_rise", 32'(ls_rise), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (20) @(posedge clock);
    // valid held high with changing settings: one transfer per IDLE visit
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      update_valid = 1'b1;
      counter_maximum = 8'($urandom_range(0, 30));
      duty_value = 8'($urandom);
      deadtime = 4'($urandom);
    end
    @(posedge clock); #1 update_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clock);
      send($urandom_range(0, 60), $urandom_range(0, 255), $urandom_range(0, 15));
    end
    repeat (150) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
